pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer sitting directly downstream of the PC input-select mux.
- Latches the selected next-instruction address (NIS) into the PC on a write strobe.
- Issues a req/ack read to instruction memory and holds the fetched word in an instruction register for decode.
- Handles redirects that arrive mid-fetch, flags misaligned targets, and counts completed fetches.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; first fetch address.
COUNT_W, 32, width of fetch_count; wraps modulo 2^COUNT_W.

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
nis  in  32  next-instruction address from PC mux
pc_write  in  1  load nis into PC (single-cycle strobe)
imem_req  out  1  instruction read request
imem_addr  out  32  read address, stable while imem_req high
imem_ack  in  1  memory response; imem_rdata valid same cycle
imem_rdata  in  32  instruction word
pc  out  32  current PC
pc_plus_4  out  32  pc + 4, modulo 2^32, combinational from pc
ir  out  32  instruction register
ir_valid  out  1  ir holds instruction for current pc
misaligned  out  1  pc[1:0] != 0; no fetch issued
fetch_count  out  COUNT_W  completed, non-discarded fetches

Behaviour:
- Reset (RST_N low, async): pc=RESET_VECTOR, imem_addr=RESET_VECTOR, ir=0, ir_valid=0, misaligned=0, fetch_count=0, state=FETCH. imem_req stays 0 while RST_N is low and becomes 1 in the first cycle after release.
- States: FETCH, HOLD, DISCARD, FAULT. imem_req=1 in FETCH and DISCARD only.
- imem_addr is a separate register. It loads pc on every entry to FETCH and never changes while imem_req is high.
- FETCH:
  - imem_ack=1, pc_write=0: ir<=imem_rdata, ir_valid<=1, fetch_count++, go to HOLD.
  - imem_ack=1, pc_write=1: response dropped (no ir or count update), pc<=nis, go to FETCH, or to FAULT if nis[1:0]!=0.
  - imem_ack=0, pc_write=1: pc<=nis, go to DISCARD; old request stays on the bus.
  - Zero-wait ack is legal: ack may be high in the first FETCH cycle.
- HOLD:
  - ir and ir_valid held until pc_write.
  - On pc_write: pc<=nis, ir_valid<=0, ir keeps its old value, go to FETCH, or to FAULT if nis[1:0]!=0.
- DISCARD:
  - Waits for ack of the abandoned request; that data is dropped.
  - pc_write here reloads pc, last write wins, and the state stays DISCARD.
  - On ack: go to FETCH at the current pc, or to FAULT if pc misaligned.
  - ack and pc_write in the same cycle: pc<=nis, then leave per the nis alignment.
- FAULT:
  - misaligned=1, ir_valid=0, no request issued.
  - pc_write with aligned nis goes to FETCH; misaligned nis stays in FAULT with the new pc.
  - misaligned is registered: high exactly while state=FAULT.
- Latency:
  - pc_write in HOLD at edge t: imem_req high with the new addr in cycle t+1.
  - With zero-wait ack, ir_valid is high in cycle t+2.
- fetch_count increments only on the FETCH->HOLD transition and wraps to 0 after all-ones.
- Reset asserted mid-operation (any state, including an outstanding request) returns everything to reset values. An ack arriving while in reset is ignored.
- Requests are strictly one outstanding; no new request is issued until the prior ack.

Test Plan:
- Reset then release, memory acks in the same cycle with 0x00000013: imem_req=1, imem_addr=0x0 in cycle 1; ir=0x00000013, ir_valid=1, fetch_count=1 in cycle 2.
- In HOLD, pc_write with nis=0x100, memory has 3 wait cycles: pc=0x100, pc_plus_4=0x104, imem_addr=0x100 held stable through all wait cycles, ir_valid=0 until the ack, then 1.
- During FETCH at 0x100 (no ack yet), pc_write with nis=0x200, ack 2 cycles later with 0xDEADBEEF: state goes to DISCARD, ir not loaded and fetch_count unchanged, then a new request at 0x200.
- pc_write and ack in the same FETCH cycle, nis=0x300: response dropped, next request at 0x300, fetch_count unchanged.
- pc_write with nis=0x102: misaligned=1, imem_req=0 for 5+ cycles; pc_write with nis=0x104 clears misaligned and fetches 0x104.
- Preload fetch_count to all-ones (COUNT_W=4: 15 fetches) then one more fetch: fetch_count=0. Assert RST_N low mid-DISCARD: all outputs return to reset values immediately.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter plus single-outstanding instruction fetch
//               sequencer with redirect discard and misalignment fault.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          COUNT_W      = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [31:0]        nis,
    input  logic               pc_write,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus_4,
    output logic [31:0]        ir,
    output logic               ir_valid,
    output logic               misaligned,
    output logic [COUNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        addr_q;
    logic [31:0]        ir_q;
    logic               ir_valid_q;
    logic               req_q;
    logic               mis_q;
    logic [COUNT_W-1:0] cnt_q;

    logic [31:0]        tgt_d;
    logic               enter_d;
    logic               tgt_mis_d;

    // enter_d marks a cycle that starts a new fetch at tgt_d (or faults on it).
    // In DISCARD a simultaneous pc_write wins over the held pc.
    always_comb begin
        tgt_d     = pc_write ? nis : pc_q;
        tgt_mis_d = (tgt_d[1:0] != 2'b00);
        enter_d   = 1'b0;
        case (state_q)
            S_FETCH:   enter_d = req_q ? (imem_ack & pc_write) : pc_write;
            S_HOLD:    enter_d = pc_write;
            S_DISCARD: enter_d = imem_ack;
            S_FAULT:   enter_d = pc_write;
            default:   enter_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_VECTOR;
            addr_q     <= RESET_VECTOR;
            ir_q       <= 32'h0;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
            mis_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // req_q low only in the first cycle after reset release
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ack && !pc_write) begin
                        ir_q       <= imem_rdata;
                        ir_valid_q <= 1'b1;
                        cnt_q      <= cnt_q + 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= S_HOLD;
                    end else if (!imem_ack && pc_write) begin
                        pc_q    <= nis;
                        state_q <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (pc_write) begin
                        pc_q <= nis;
                    end
                end
                default: begin
                end
            endcase

            if (enter_d) begin
                pc_q       <= tgt_d;
                ir_valid_q <= 1'b0;
                mis_q      <= tgt_mis_d;
                req_q      <= !tgt_mis_d;
                if (tgt_mis_d) begin
                    state_q <= S_FAULT;
                end else begin
                    state_q <= S_FETCH;
                    addr_q  <= tgt_d;
                end
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pc          = pc_q;
    assign pc_plus_4   = pc_q + 32'd4;
    assign ir          = ir_q;
    assign ir_valid    = ir_valid_q;
    assign misaligned  = mis_q;
    assign fetch_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit (COUNT_W=4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] nis;
    logic        pc_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] ir;
    logic        ir_valid;
    logic        misaligned;
    logic [3:0]  fetch_count;

    int checks;
    int errors;

    pc_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .COUNT_W      (4)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .nis         (nis),
        .pc_write    (pc_write),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc_plus_4   (pc_plus_4),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .misaligned  (misaligned),
        .fetch_count (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Redirect from HOLD and answer with a zero-wait ack.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        nis = addr; pc_write = 1'b1;
        tick();
        pc_write = 1'b0; imem_ack = 1'b1; imem_rdata = data;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_0000;
        pc_write = 1'b0; nis = 32'h0;
        repeat (2) tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_pc got pc=%h addr=%h exp 0", pc, imem_addr); end
        checks++; if (ir !== 32'h0 || ir_valid !== 1'b0 || misaligned !== 1'b0 || fetch_count !== 4'h0) begin
            errors++; $display("FAIL rst_state got ir=%h v=%b mis=%b cnt=%h exp 0", ir, ir_valid, misaligned, fetch_count); end
        imem_ack = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        imem_ack = 1'b0;
        checks++; if (ir !== 32'h0000_0013 || ir_valid !== 1'b1 || fetch_count !== 4'h1) begin
            errors++; $display("FAIL first_fetch got ir=%h v=%b cnt=%h exp 00000013/1/1", ir, ir_valid, fetch_count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got %b exp 0", imem_req); end
    endtask

    task automatic test_wait_states();
        nis = 32'h100; pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        checks++; if (pc !== 32'h100 || pc_plus_4 !== 32'h104) begin errors++; $display("FAIL wait_pc got pc=%h p4=%h exp 100/104", pc, pc_plus_4); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h100 || ir_valid !== 1'b0) begin
                errors++; $display("FAIL wait_cycle%0d got req=%b addr=%h v=%b exp 1/100/0", i, imem_req, imem_addr, ir_valid);
            end
            if (i < 2) tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'h0000_1111;
        tick();
        imem_ack = 1'b0;
        checks++; if (ir !== 32'h0000_1111 || ir_valid !== 1'b1 || fetch_count !== 4'h2) begin
            errors++; $display("FAIL wait_done got ir=%h v=%b cnt=%h exp 00001111/1/2", ir, ir_valid, fetch_count); end
    endtask

    task automatic test_redirect_discard();
        nis = 32'h100; pc_write = 1'b1;
        tick();
        nis = 32'h200;
        tick();
        pc_write = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || pc !== 32'h200) begin
            errors++; $display("FAIL discard_hold got req=%b addr=%h pc=%h exp 1/100/200", imem_req, imem_addr, pc); end
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL discard_refetch got req=%b addr=%h exp 1/200", imem_req, imem_addr); end
        checks++; if (ir !== 32'h0000_1111 || ir_valid !== 1'b0 || fetch_count !== 4'h2) begin
            errors++; $display("FAIL discard_drop got ir=%h v=%b cnt=%h exp 00001111/0/2", ir, ir_valid, fetch_count); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_2222;
        tick();
        imem_ack = 1'b0;
        checks++; if (ir !== 32'h0000_2222 || fetch_count !== 4'h3) begin
            errors++; $display("FAIL discard_next got ir=%h cnt=%h exp 00002222/3", ir, fetch_count); end
    endtask

    task automatic test_same_cycle();
        nis = 32'h280; pc_write = 1'b1;
        tick();
        nis = 32'h300; imem_ack = 1'b1; imem_rdata = 32'h0000_0055;
        tick();
        pc_write = 1'b0; imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || pc !== 32'h300) begin
            errors++; $display("FAIL same_refetch got req=%b addr=%h pc=%h exp 1/300/300", imem_req, imem_addr, pc); end
        checks++; if (ir !== 32'h0000_2222 || ir_valid !== 1'b0 || fetch_count !== 4'h3) begin
            errors++; $display("FAIL same_drop got ir=%h v=%b cnt=%h exp 00002222/0/3", ir, ir_valid, fetch_count); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_3333;
        tick();
        imem_ack = 1'b0;
        checks++; if (ir !== 32'h0000_3333 || fetch_count !== 4'h4) begin
            errors++; $display("FAIL same_next got ir=%h cnt=%h exp 00003333/4", ir, fetch_count); end
    endtask

    task automatic test_misaligned();
        nis = 32'h102; pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        checks++; if (misaligned !== 1'b1 || ir_valid !== 1'b0 || pc !== 32'h102) begin
            errors++; $display("FAIL mis_enter got mis=%b v=%b pc=%h exp 1/0/102", misaligned, ir_valid, pc); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_req !== 1'b0 || misaligned !== 1'b1) begin
                errors++; $display("FAIL mis_idle%0d got req=%b mis=%b exp 0/1", i, imem_req, misaligned);
            end
            tick();
        end
        nis = 32'h106; pc_write = 1'b1;
        tick();
        checks++; if (misaligned !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h106) begin
            errors++; $display("FAIL mis_again got mis=%b req=%b pc=%h exp 1/0/106", misaligned, imem_req, pc); end
        nis = 32'h104;
        tick();
        pc_write = 1'b0;
        checks++; if (misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin
            errors++; $display("FAIL mis_clear got mis=%b req=%b addr=%h exp 0/1/104", misaligned, imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_4444;
        tick();
        imem_ack = 1'b0;
        checks++; if (ir !== 32'h0000_4444 || ir_valid !== 1'b1 || fetch_count !== 4'h5) begin
            errors++; $display("FAIL mis_fetch got ir=%h v=%b cnt=%h exp 00004444/1/5", ir, ir_valid, fetch_count); end
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 10; i++) begin
            do_fetch(32'h1000 + 32'(i * 4), 32'hC000_0000 + 32'(i));
        end
        checks++; if (fetch_count !== 4'hF || ir !== 32'hC000_0009) begin
            errors++; $display("FAIL cnt_full got cnt=%h ir=%h exp f/c0000009", fetch_count, ir); end
        do_fetch(32'h2000, 32'h0000_5555);
        checks++; if (fetch_count !== 4'h0 || ir_valid !== 1'b1) begin
            errors++; $display("FAIL cnt_wrap got cnt=%h v=%b exp 0/1", fetch_count, ir_valid); end
    endtask

    task automatic test_reset_mid_discard();
        nis = 32'h400; pc_write = 1'b1;
        tick();
        nis = 32'h500;
        tick();
        pc_write = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || pc !== 32'h500) begin
            errors++; $display("FAIL pre_rst got req=%b addr=%h pc=%h exp 1/400/500", imem_req, imem_addr, pc); end
        #2;
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0 || ir !== 32'h0 ||
                      ir_valid !== 1'b0 || misaligned !== 1'b0 || fetch_count !== 4'h0) begin
            errors++; $display("FAIL async_rst got req=%b pc=%h addr=%h ir=%h v=%b mis=%b cnt=%h exp all 0",
                               imem_req, pc, imem_addr, ir, ir_valid, misaligned, fetch_count); end
        tick();
        checks++; if (imem_req !== 1'b0 || ir !== 32'h0 || fetch_count !== 4'h0) begin
            errors++; $display("FAIL rst_ack_ignored got req=%b ir=%h cnt=%h exp 0/0/0", imem_req, ir, fetch_count); end
        imem_ack = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_restart got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; nis = 32'h0; pc_write = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_wait_states();
        test_redirect_discard();
        test_same_cycle();
        test_misaligned();
        test_count_wrap();
        test_reset_mid_discard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
